// File: rtl/l1c_arb_pkg.sv
// Shared constants, geometry and FSM state type for the L1 cache tag/data
// SRAM arbiter.
package l1c_arb_pkg;

  localparam int unsigned PORT_NUM = 3;
  localparam int unsigned REFILL   = 0;
  localparam int unsigned VICTIM   = 1;
  localparam int unsigned LOOKUP   = 2;

  localparam int unsigned L1C_SET_NUM      = 512;
  localparam int unsigned L1C_OFFSET_WIDTH = 6;
  localparam int unsigned L1C_ADDR_WIDTH   = 48;
  localparam int unsigned L1C_INDEX_WIDTH  = $clog2(L1C_SET_NUM);
  localparam int unsigned L1C_TAG_WIDTH    = L1C_ADDR_WIDTH - L1C_INDEX_WIDTH - L1C_OFFSET_WIDTH;
  localparam int unsigned L1C_DATA_WIDTH   = 512;
  localparam int unsigned L1C_STALL_LIMIT  = 16;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } arb_state_e;

endpackage

// File: rtl/l1c_arb_prio.sv
// Starvation-aware fixed-priority selector: starved requesters form the upper
// class; inside a class the lowest port index wins.
module l1c_arb_prio
  import l1c_arb_pkg::*;
(
  input  logic [PORT_NUM-1:0] i_valid,
  input  logic [PORT_NUM-1:0] i_starved,
  output logic [PORT_NUM-1:0] o_grant
);

  logic [PORT_NUM-1:0] w_starved_req;
  logic [PORT_NUM-1:0] w_cand;

  always_comb begin
    w_starved_req = i_valid & i_starved;
    w_cand        = (|w_starved_req) ? w_starved_req : i_valid;
    // Isolate the lowest set bit: refill > victim > lookup.
    o_grant       = w_cand & (~w_cand + PORT_NUM'(1));
  end

endmodule

// File: rtl/l1c_mem_arb.sv
// Shares the single-ported L1C tag/data SRAM between refill, victim and lookup
// requesters and sweeps invalid tags over every set after reset and on flush.
module l1c_mem_arb
  import l1c_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = L1C_DATA_WIDTH,
  parameter int unsigned SET_NUM     = L1C_SET_NUM,
  parameter int unsigned INDEX_WIDTH = $clog2(SET_NUM),
  parameter int unsigned TAG_WIDTH   = L1C_TAG_WIDTH,
  parameter int unsigned STALL_LIMIT = L1C_STALL_LIMIT
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [PORT_NUM-1:0]               req_valid_i,
  output logic [PORT_NUM-1:0]               req_ready_o,
  input  logic [PORT_NUM-1:0]               req_we_i,
  input  logic [PORT_NUM*INDEX_WIDTH-1:0]   req_index_i,
  input  logic [PORT_NUM*TAG_WIDTH-1:0]     req_tag_i,
  input  logic [PORT_NUM*DATA_WIDTH-1:0]    req_data_i,
  input  logic                              flush_i,
  output logic                              mem_req_o,
  output logic                              mem_we_o,
  output logic [INDEX_WIDTH-1:0]            mem_index_o,
  output logic [TAG_WIDTH-1:0]              mem_tag_o,
  output logic                              mem_vbit_o,
  output logic [DATA_WIDTH-1:0]             mem_data_o,
  input  logic [TAG_WIDTH-1:0]              mem_rtag_i,
  input  logic                              mem_rvbit_i,
  input  logic [DATA_WIDTH-1:0]             mem_rdata_i,
  output logic [PORT_NUM-1:0]               rsp_valid_o,
  output logic [TAG_WIDTH-1:0]              rsp_tag_o,
  output logic                              rsp_vbit_o,
  output logic [DATA_WIDTH-1:0]             rsp_data_o,
  output logic                              init_done_o
);

  localparam int unsigned CNT_WIDTH = $clog2(STALL_LIMIT + 1);

  arb_state_e             r_state;
  logic [INDEX_WIDTH-1:0] r_sweep;
  logic [CNT_WIDTH-1:0]   r_stall [PORT_NUM];
  logic [PORT_NUM-1:0]    r_rsp_valid;

  logic                   w_run;
  logic                   w_sweep;
  logic                   w_sweep_last;
  logic [PORT_NUM-1:0]    w_valid;
  logic [PORT_NUM-1:0]    w_starved;
  logic [PORT_NUM-1:0]    w_grant;

  assign w_run        = (r_state == ST_RUN);
  assign w_sweep      = (r_state == ST_INIT) || (r_state == ST_FLUSH);
  assign w_sweep_last = (r_sweep == INDEX_WIDTH'(SET_NUM - 1));
  // A flush request takes the whole cycle: nobody is granted.
  assign w_valid      = (w_run && !flush_i) ? req_valid_i : '0;

  always_comb begin
    for (int i = 0; i < PORT_NUM; i++) begin
      w_starved[i] = (r_stall[i] == CNT_WIDTH'(STALL_LIMIT));
    end
  end

  l1c_arb_prio u_prio (
    .i_valid   (w_valid),
    .i_starved (w_starved),
    .o_grant   (w_grant)
  );

  assign req_ready_o = w_grant;

  // SRAM command: sweep writes invalid tags, otherwise the granted port drives.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_index_o = '0;
    mem_tag_o   = '0;
    mem_vbit_o  = 1'b0;
    mem_data_o  = '0;
    if (w_sweep) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_index_o = r_sweep;
    end else begin
      for (int i = 0; i < PORT_NUM; i++) begin
        if (w_grant[i]) begin
          mem_req_o   = 1'b1;
          mem_we_o    = req_we_i[i];
          mem_index_o = req_index_i[i*INDEX_WIDTH +: INDEX_WIDTH];
          mem_tag_o   = req_tag_i[i*TAG_WIDTH +: TAG_WIDTH];
          mem_vbit_o  = 1'b1;
          mem_data_o  = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_RST;
      r_sweep     <= '0;
      r_rsp_valid <= '0;
      for (int i = 0; i < PORT_NUM; i++) begin
        r_stall[i] <= '0;
      end
    end else begin
      r_rsp_valid <= w_grant & ~req_we_i;
      for (int i = 0; i < PORT_NUM; i++) begin
        if (w_run && req_valid_i[i] && !w_grant[i]) begin
          if (!w_starved[i]) begin
            r_stall[i] <= r_stall[i] + CNT_WIDTH'(1);
          end
        end else begin
          r_stall[i] <= '0;
        end
      end
      case (r_state)
        ST_RST: r_state <= ST_INIT;
        ST_INIT, ST_FLUSH: begin
          if (w_sweep_last) begin
            r_state <= ST_RUN;
            r_sweep <= '0;
          end else begin
            r_sweep <= r_sweep + INDEX_WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (flush_i) begin
            r_state <= ST_FLUSH;
          end
        end
        default: r_state <= ST_RST;
      endcase
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_tag_o   = mem_rtag_i;
  assign rsp_vbit_o  = mem_rvbit_i;
  assign rsp_data_o  = mem_rdata_i;
  assign init_done_o = (r_state == ST_RUN);

endmodule

// File: tb/tb_l1c_mem_arb.sv
// Directed bench for l1c_mem_arb: SRAM model, response scoreboard and a
// per-cycle sweep monitor driven from one sequential initial block.
module tb_l1c_mem_arb;
  import l1c_arb_pkg::*;

  localparam int unsigned DW = 512;
  localparam int unsigned IW = 9;
  localparam int unsigned TW = 33;

  localparam logic [TW-1:0] T1 = 33'h1_2345_6789;
  localparam logic [TW-1:0] T2 = 33'h0_ABCD_0123;
  localparam logic [TW-1:0] T3 = 33'h1_FFFF_0000;
  localparam logic [63:0]   D1 = 64'hA5A5_0000_0000_0001;
  localparam logic [63:0]   D2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0]   D3 = 64'hDEAD_BEEF_0000_0003;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic [2:0]      req_valid_i, req_ready_o, req_we_i;
  logic [3*IW-1:0] req_index_i;
  logic [3*TW-1:0] req_tag_i;
  logic [3*DW-1:0] req_data_i;
  logic            flush_i;
  logic            mem_req_o, mem_we_o, mem_vbit_o;
  logic [IW-1:0]   mem_index_o;
  logic [TW-1:0]   mem_tag_o, mem_rtag_i, rsp_tag_o;
  logic [DW-1:0]   mem_data_o, mem_rdata_i, rsp_data_o;
  logic            mem_rvbit_i, rsp_vbit_o, init_done_o;
  logic [2:0]      rsp_valid_o;

  l1c_mem_arb dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_index_i (req_index_i),
    .req_tag_i   (req_tag_i),
    .req_data_i  (req_data_i),
    .flush_i     (flush_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_index_o (mem_index_o),
    .mem_tag_o   (mem_tag_o),
    .mem_vbit_o  (mem_vbit_o),
    .mem_data_o  (mem_data_o),
    .mem_rtag_i  (mem_rtag_i),
    .mem_rvbit_i (mem_rvbit_i),
    .mem_rdata_i (mem_rdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_tag_o   (rsp_tag_o),
    .rsp_vbit_o  (rsp_vbit_o),
    .rsp_data_o  (rsp_data_o),
    .init_done_o (init_done_o)
  );

  always #5 clk_i = ~clk_i;

  // Single-ported SRAM model with one-cycle read latency.
  logic [TW-1:0] m_tag  [512];
  logic          m_vbit [512];
  logic [DW-1:0] m_data [512];

  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        m_tag[mem_index_o]  <= mem_tag_o;
        m_vbit[mem_index_o] <= mem_vbit_o;
        m_data[mem_index_o] <= mem_data_o;
      end else begin
        mem_rtag_i  <= m_tag[mem_index_o];
        mem_rvbit_i <= m_vbit[mem_index_o];
        mem_rdata_i <= m_data[mem_index_o];
      end
    end
  end

  typedef struct {
    int unsigned   due;
    logic [2:0]    port;
    logic [TW-1:0] tag;
    logic          vbit;
    logic [63:0]   dlo;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned sweep_seen = 0;
  int unsigned sweep_err = 0;
  logic [IW-1:0] sweep_idx = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int unsigned p, input logic v, input logic we,
                          input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                          input logic [63:0] dlo);
    req_valid_i[p]          = v;
    req_we_i[p]             = we;
    req_index_i[p*IW +: IW] = idx;
    req_tag_i[p*TW +: TW]   = tag;
    req_data_i[p*DW +: DW]  = {8{dlo}};
  endtask

  task automatic expect_rsp(input logic [2:0] port, input logic [TW-1:0] tag,
                            input logic vbit, input logic [63:0] dlo);
    exp_t e;
    e.due  = cyc + 1;
    e.port = port;
    e.tag  = tag;
    e.vbit = vbit;
    e.dlo  = dlo;
    sb.push_back(e);
  endtask

  task automatic chk_grant(input string tag, input logic [2:0] exp);
    #1;
    check(tag, 64'(req_ready_o), 64'(exp));
  endtask

  // Sample mid-cycle (sweep monitor + response scoreboard), then step to the next edge.
  task automatic cycle();
    exp_t       e;
    logic [2:0] exp_rv;
    @(negedge clk_i);
    if (mem_req_o && mem_we_o && !mem_vbit_o) begin
      if (mem_index_o !== sweep_idx || mem_tag_o !== '0 || mem_data_o !== '0 || req_ready_o !== 3'b000)
        sweep_err++;
      sweep_idx = sweep_idx + IW'(1);
      sweep_seen++;
    end
    exp_rv = 3'b000;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e      = sb.pop_front();
      exp_rv = e.port;
      check("rsp_tag", 64'(rsp_tag_o), 64'(e.tag));
      check("rsp_vbit", 64'(rsp_vbit_o), 64'(e.vbit));
      check("rsp_data", rsp_data_o[63:0], e.dlo);
    end
    check("rsp_valid", 64'(rsp_valid_o), 64'(exp_rv));
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned n;
    int unsigned base;
    rst_ni      = 1'b0;
    flush_i     = 1'b0;
    req_valid_i = '0;
    req_we_i    = '0;
    req_index_i = '0;
    req_tag_i   = '0;
    req_data_i  = '0;
    set_port(REFILL, 1'b1, 1'b1, 9'd1, T3, D3);
    set_port(VICTIM, 1'b1, 1'b0, 9'd2, '0, '0);
    set_port(LOOKUP, 1'b1, 1'b0, 9'd3, '0, '0);
    #2;
    check("rst_ready", 64'(req_ready_o), 64'(0));
    check("rst_mem_req", 64'(mem_req_o), 64'(0));
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    check("rst_init_done", 64'(init_done_o), 64'(0));
    repeat (2) cycle();

    // Reset release: a lookup waits through the whole sweep.
    set_port(REFILL, 1'b0, 1'b0, '0, '0, '0);
    set_port(VICTIM, 1'b0, 1'b0, '0, '0, '0);
    set_port(LOOKUP, 1'b1, 1'b0, 9'd7, '0, '0);
    rst_ni = 1'b1;
    n = 0;
    while (!init_done_o && n < 600) begin
      cycle();
      n++;
    end
    check("init_len", 64'(n), 64'(513));
    check("init_writes", 64'(sweep_seen), 64'(512));
    check("init_sweep_ok", 64'(sweep_err), 64'(0));
    chk_grant("init_wait_lookup", 3'b100);
    expect_rsp(3'b100, '0, 1'b0, '0);
    cycle();
    set_port(LOOKUP, 1'b0, 1'b0, '0, '0, '0);
    cycle();

    // Same-cycle refill write and lookup read of set 5.
    set_port(REFILL, 1'b1, 1'b1, 9'd5, T1, D1);
    set_port(LOOKUP, 1'b1, 1'b0, 9'd5, '0, '0);
    chk_grant("refill_first", 3'b001);
    check("refill_we", 64'(mem_we_o), 64'(1));
    check("refill_index", 64'(mem_index_o), 64'(5));
    check("refill_tag", 64'(mem_tag_o), 64'(T1));
    check("refill_vbit", 64'(mem_vbit_o), 64'(1));
    check("refill_data", mem_data_o[63:0], D1);
    cycle();
    set_port(REFILL, 1'b0, 1'b0, '0, '0, '0);
    chk_grant("lookup_second", 3'b100);
    check("lookup_we", 64'(mem_we_o), 64'(0));
    expect_rsp(3'b100, T1, 1'b1, D1);
    cycle();
    set_port(LOOKUP, 1'b0, 1'b0, '0, '0, '0);
    #1;
    check("idle_no_req", 64'(mem_req_o), 64'(0));
    cycle();

    // Lookup starved by a continuous refill stream.
    set_port(REFILL, 1'b1, 1'b1, 9'd10, T2, D2);
    set_port(LOOKUP, 1'b1, 1'b0, 9'd5, '0, '0);
    for (int k = 0; k < 16; k++) begin
      chk_grant("starve_lose", 3'b001);
      cycle();
    end
    chk_grant("starve_win", 3'b100);
    expect_rsp(3'b100, T1, 1'b1, D1);
    cycle();
    set_port(LOOKUP, 1'b1, 1'b0, 9'd10, '0, '0);
    chk_grant("starve_cnt_cleared", 3'b001);
    cycle();
    set_port(REFILL, 1'b0, 1'b0, '0, '0, '0);
    chk_grant("lookup_after_refill", 3'b100);
    expect_rsp(3'b100, T2, 1'b1, D2);
    cycle();
    set_port(LOOKUP, 1'b0, 1'b0, '0, '0, '0);
    cycle();

    // Victim and lookup both starved: victim first.
    set_port(REFILL, 1'b1, 1'b1, 9'd10, T2, D2);
    set_port(VICTIM, 1'b1, 1'b0, 9'd5, '0, '0);
    set_port(LOOKUP, 1'b1, 1'b0, 9'd10, '0, '0);
    for (int k = 0; k < 16; k++) begin
      chk_grant("both_starve_lose", 3'b001);
      cycle();
    end
    chk_grant("starved_victim", 3'b010);
    expect_rsp(3'b010, T1, 1'b1, D1);
    cycle();
    set_port(VICTIM, 1'b0, 1'b0, '0, '0, '0);
    chk_grant("starved_lookup", 3'b100);
    expect_rsp(3'b100, T2, 1'b1, D2);
    cycle();
    set_port(LOOKUP, 1'b0, 1'b0, '0, '0, '0);
    set_port(REFILL, 1'b0, 1'b0, '0, '0, '0);
    cycle();

    // Read granted just before a flush still completes.
    set_port(LOOKUP, 1'b1, 1'b0, 9'd5, '0, '0);
    chk_grant("pre_flush_read", 3'b100);
    expect_rsp(3'b100, T1, 1'b1, D1);
    cycle();
    set_port(LOOKUP, 1'b0, 1'b0, '0, '0, '0);
    set_port(REFILL, 1'b1, 1'b1, 9'd20, T3, D3);
    flush_i = 1'b1;
    chk_grant("flush_no_grant", 3'b000);
    check("flush_no_req", 64'(mem_req_o), 64'(0));
    base = sweep_seen;
    cycle();
    flush_i = 1'b0;
    check("flush_done_low", 64'(init_done_o), 64'(0));
    n = 0;
    while (!init_done_o && n < 600) begin
      cycle();
      n++;
    end
    check("flush_len", 64'(n), 64'(512));
    check("flush_writes", 64'(sweep_seen - base), 64'(512));
    chk_grant("post_flush_refill", 3'b001);
    cycle();
    set_port(REFILL, 1'b0, 1'b0, '0, '0, '0);
    set_port(LOOKUP, 1'b1, 1'b0, 9'd5, '0, '0);
    chk_grant("post_flush_read", 3'b100);
    expect_rsp(3'b100, '0, 1'b0, '0);
    cycle();
    set_port(LOOKUP, 1'b0, 1'b0, '0, '0, '0);
    cycle();

    // Reset in the middle of a flush sweep restarts from index 0.
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    base = sweep_seen;
    n = 0;
    while (sweep_seen - base < 200 && n < 600) begin
      cycle();
      n++;
    end
    check("sweep_at_200", 64'(mem_index_o), 64'(200));
    rst_ni = 1'b0;
    #1;
    check("midrst_ready", 64'(req_ready_o), 64'(0));
    check("midrst_mem_req", 64'(mem_req_o), 64'(0));
    check("midrst_rsp_valid", 64'(rsp_valid_o), 64'(0));
    check("midrst_init_done", 64'(init_done_o), 64'(0));
    repeat (2) cycle();
    sweep_idx = '0;
    base = sweep_seen;
    rst_ni = 1'b1;
    n = 0;
    while (!init_done_o && n < 600) begin
      cycle();
      n++;
    end
    check("reinit_len", 64'(n), 64'(513));
    check("reinit_writes", 64'(sweep_seen - base), 64'(512));
    check("sweep_contents", 64'(sweep_err), 64'(0));
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
